// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter, stack pointer and memory address register.
// Executes the control FSM's PC/SP/MAR strobes; sources imem/dmem addresses.
//
// Ports:
//   CLK, RESET            clock (rising edge), synchronous active-high reset
//   INC/CLR/WRITE_PROGCOUNT  PC strobes (CLR > WRITE > INC)
//   READ_PROGCOUNT        drive PC onto MEM_WDATA instead of ALU_RESULT
//   READ_MEM              PC load source is MEM_RDATA (RET)
//   WRITE_MEMADDR         load MAR (from SP if READ_STACKPTR, else ALU_RESULT)
//   PRESET/INC/DEC_STACKPTR  SP strobes (PRESET > INC xor DEC)
//   READ_STACKPTR         MAR source select
//   ALU_RESULT, MEM_RDATA data inputs
//   PC, MAR, SP_OUT       registered state
//   MEM_WDATA             combinational write data
//   STACK_DEPTH           SP_INIT - SP
//   STACK_OVF, STACK_UNF  sticky stack faults
//
// Build option: define YASAC_STACK_GUARD_EN to saturate SP at the stack
// bounds and raise sticky fault flags; otherwise SP wraps and flags read 0.

module pc_stack_unit #(
    parameter int unsigned           PC_WIDTH   = 8,
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] SP_INIT    = 8'hFF,
    parameter logic [ADDR_WIDTH-1:0] SP_LIMIT   = 8'hC0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  INC_PROGCOUNT,
    input  logic                  CLR_PROGCOUNT,
    input  logic                  WRITE_PROGCOUNT,
    input  logic                  READ_PROGCOUNT,
    input  logic                  READ_MEM,
    input  logic                  WRITE_MEMADDR,
    input  logic                  PRESET_STACKPTR,
    input  logic                  INC_STACKPTR,
    input  logic                  DEC_STACKPTR,
    input  logic                  READ_STACKPTR,
    input  logic [7:0]            ALU_RESULT,
    input  logic [7:0]            MEM_RDATA,
    output logic [PC_WIDTH-1:0]   PC,
    output logic [ADDR_WIDTH-1:0] MAR,
    output logic [7:0]            MEM_WDATA,
    output logic [ADDR_WIDTH-1:0] SP_OUT,
    output logic [ADDR_WIDTH-1:0] STACK_DEPTH,
    output logic                  STACK_OVF,
    output logic                  STACK_UNF
);

    if (SP_LIMIT == '0 || SP_LIMIT > SP_INIT) begin : g_bad_limit
        $error("pc_stack_unit: SP_LIMIT must lie in [1, SP_INIT]");
    end

    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] mar_q, mar_d;
    logic [ADDR_WIDTH-1:0] sp_q, sp_d;
    logic                  sp_push, sp_pop;

    // INC and DEC together cancel out: no movement, no fault.
    assign sp_push = DEC_STACKPTR & ~INC_STACKPTR;
    assign sp_pop  = INC_STACKPTR & ~DEC_STACKPTR;

    always_comb begin
        pc_d = pc_q;
        if (CLR_PROGCOUNT)
            pc_d = '0;
        else if (WRITE_PROGCOUNT)
            pc_d = READ_MEM ? PC_WIDTH'(MEM_RDATA) : PC_WIDTH'(ALU_RESULT);
        else if (INC_PROGCOUNT)
            pc_d = pc_q + 1'b1;
    end

    // MAR samples the pre-update SP, so a PUSH addresses the old free slot.
    always_comb begin
        mar_d = mar_q;
        if (WRITE_MEMADDR)
            mar_d = READ_STACKPTR ? sp_q : ADDR_WIDTH'(ALU_RESULT);
    end

`ifdef YASAC_STACK_GUARD_EN
    localparam logic [ADDR_WIDTH-1:0] SP_FULL = ADDR_WIDTH'(SP_LIMIT - 1'b1);

    logic ovf_q, ovf_d;
    logic unf_q, unf_d;
    logic ovf_ev, unf_ev;

    assign ovf_ev = sp_push && (sp_q == SP_FULL);
    assign unf_ev = sp_pop && (sp_q == SP_INIT);

    // A faulting push/pop leaves SP saturated at the bound.
    always_comb begin
        sp_d  = sp_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (PRESET_STACKPTR) begin
            sp_d  = SP_INIT;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else if (ovf_ev) begin
            ovf_d = 1'b1;
        end else if (unf_ev) begin
            unf_d = 1'b1;
        end else if (sp_push) begin
            sp_d = sp_q - 1'b1;
        end else if (sp_pop) begin
            sp_d = sp_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign STACK_OVF = ovf_q;
    assign STACK_UNF = unf_q;
`else
    always_comb begin
        sp_d = sp_q;
        if (PRESET_STACKPTR)
            sp_d = SP_INIT;
        else if (sp_push)
            sp_d = sp_q - 1'b1;
        else if (sp_pop)
            sp_d = sp_q + 1'b1;
    end

    assign STACK_OVF = 1'b0;
    assign STACK_UNF = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_q  <= '0;
            sp_q  <= SP_INIT;
            mar_q <= '0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            mar_q <= mar_d;
        end
    end

    assign PC          = pc_q;
    assign MAR         = mar_q;
    assign SP_OUT      = sp_q;
    assign STACK_DEPTH = SP_INIT - sp_q;
    assign MEM_WDATA   = READ_PROGCOUNT ? 8'(pc_q) : ALU_RESULT;

endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit: directed scenarios plus randomized strobes checked
// against an integer-arithmetic reference model of PC/SP/MAR behaviour.

module tb_pc_stack_unit;

`ifdef YASAC_STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
    localparam logic [7:0] EXP_SP_OVF  = 8'hBF;
    localparam logic       EXP_OVF     = 1'b1;
    localparam logic [7:0] EXP_DEP_OVF = 8'h40;
    localparam logic [7:0] EXP_SP_UNF  = 8'hFF;
    localparam logic       EXP_UNF     = 1'b1;
`else
    localparam bit GUARD = 1'b0;
    localparam logic [7:0] EXP_SP_OVF  = 8'hBE;
    localparam logic       EXP_OVF     = 1'b0;
    localparam logic [7:0] EXP_DEP_OVF = 8'h41;
    localparam logic [7:0] EXP_SP_UNF  = 8'h00;
    localparam logic       EXP_UNF     = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESET;
    logic       INC_PROGCOUNT, CLR_PROGCOUNT, WRITE_PROGCOUNT;
    logic       READ_PROGCOUNT, READ_MEM, WRITE_MEMADDR;
    logic       PRESET_STACKPTR, INC_STACKPTR, DEC_STACKPTR, READ_STACKPTR;
    logic [7:0] ALU_RESULT, MEM_RDATA;
    logic [7:0] PC, MAR, MEM_WDATA, SP_OUT, STACK_DEPTH;
    logic       STACK_OVF, STACK_UNF;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int m_pc, m_sp, m_mar;
    bit m_ovf, m_unf;

    pc_stack_unit dut (
        .CLK(CLK), .RESET(RESET),
        .INC_PROGCOUNT(INC_PROGCOUNT), .CLR_PROGCOUNT(CLR_PROGCOUNT),
        .WRITE_PROGCOUNT(WRITE_PROGCOUNT), .READ_PROGCOUNT(READ_PROGCOUNT),
        .READ_MEM(READ_MEM), .WRITE_MEMADDR(WRITE_MEMADDR),
        .PRESET_STACKPTR(PRESET_STACKPTR), .INC_STACKPTR(INC_STACKPTR),
        .DEC_STACKPTR(DEC_STACKPTR), .READ_STACKPTR(READ_STACKPTR),
        .ALU_RESULT(ALU_RESULT), .MEM_RDATA(MEM_RDATA),
        .PC(PC), .MAR(MAR), .MEM_WDATA(MEM_WDATA), .SP_OUT(SP_OUT),
        .STACK_DEPTH(STACK_DEPTH), .STACK_OVF(STACK_OVF), .STACK_UNF(STACK_UNF)
    );

    always #5 CLK = ~CLK;

    task automatic idle();
        RESET = 0; INC_PROGCOUNT = 0; CLR_PROGCOUNT = 0; WRITE_PROGCOUNT = 0;
        READ_PROGCOUNT = 0; READ_MEM = 0; WRITE_MEMADDR = 0;
        PRESET_STACKPTR = 0; INC_STACKPTR = 0; DEC_STACKPTR = 0;
        READ_STACKPTR = 0; ALU_RESULT = 8'h00; MEM_RDATA = 8'h00;
    endtask

    // Reference model: applies one clock edge using the currently driven strobes.
    // Stack bounds: empty at 255, last legal slot at 0xC0-1.
    task automatic model_edge();
        int old_sp;
        old_sp = m_sp;
        if (RESET) begin
            m_pc = 0; m_sp = 255; m_mar = 0; m_ovf = 0; m_unf = 0;
            return;
        end
        if (CLR_PROGCOUNT) m_pc = 0;
        else if (WRITE_PROGCOUNT) m_pc = READ_MEM ? int'(MEM_RDATA) : int'(ALU_RESULT);
        else if (INC_PROGCOUNT) m_pc = (m_pc + 1) % 256;
        if (WRITE_MEMADDR) m_mar = READ_STACKPTR ? old_sp : int'(ALU_RESULT);
        if (PRESET_STACKPTR) begin
            m_sp = 255; m_ovf = 0; m_unf = 0;
        end else if (DEC_STACKPTR && !INC_STACKPTR) begin
            if (GUARD && old_sp == 'hC0 - 1) m_ovf = 1;
            else m_sp = (old_sp + 255) % 256;
        end else if (INC_STACKPTR && !DEC_STACKPTR) begin
            if (GUARD && old_sp == 255) m_unf = 1;
            else m_sp = (old_sp + 1) % 256;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        idle(); RESET = 1; tick(); idle();
        n_cmp++; if (PC !== 8'h00) begin n_bad++; $display("FAIL rst_pc got %h want 00", PC); end
        n_cmp++; if (SP_OUT !== 8'hFF) begin n_bad++; $display("FAIL rst_sp got %h want ff", SP_OUT); end
        n_cmp++; if (MAR !== 8'h00) begin n_bad++; $display("FAIL rst_mar got %h want 00", MAR); end
        n_cmp++; if (STACK_DEPTH !== 8'h00) begin n_bad++; $display("FAIL rst_depth got %h want 00", STACK_DEPTH); end
        n_cmp++; if ({STACK_OVF, STACK_UNF} !== 2'b00) begin n_bad++; $display("FAIL rst_flags got %b want 00", {STACK_OVF, STACK_UNF}); end
        INC_PROGCOUNT = 1;
        repeat (3) tick();
        n_cmp++; if (PC !== 8'h03) begin n_bad++; $display("FAIL inc3_pc got %h want 03", PC); end
        n_cmp++; if (SP_OUT !== 8'hFF) begin n_bad++; $display("FAIL inc3_sp got %h want ff", SP_OUT); end
        RESET = 1; tick();
        n_cmp++; if (PC !== 8'h00) begin n_bad++; $display("FAIL midrst_pc got %h want 00", PC); end
        // reset in the middle of a PUSH
        idle(); DEC_STACKPTR = 1; READ_STACKPTR = 1; WRITE_MEMADDR = 1; RESET = 1; tick(); idle();
        n_cmp++; if (SP_OUT !== 8'hFF) begin n_bad++; $display("FAIL rstpush_sp got %h want ff", SP_OUT); end
        n_cmp++; if (MAR !== 8'h00) begin n_bad++; $display("FAIL rstpush_mar got %h want 00", MAR); end
    endtask

    task automatic test_call_ret();
        idle(); WRITE_PROGCOUNT = 1; ALU_RESULT = 8'h12; tick(); idle();
        READ_STACKPTR = 1; WRITE_MEMADDR = 1; DEC_STACKPTR = 1; tick(); idle();
        n_cmp++; if (MAR !== 8'hFF) begin n_bad++; $display("FAIL call_mar got %h want ff", MAR); end
        n_cmp++; if (SP_OUT !== 8'hFE) begin n_bad++; $display("FAIL call_sp got %h want fe", SP_OUT); end
        READ_PROGCOUNT = 1; ALU_RESULT = 8'h77; #1;
        n_cmp++; if (MEM_WDATA !== 8'h12) begin n_bad++; $display("FAIL call_wdata got %h want 12", MEM_WDATA); end
        tick(); idle();
        WRITE_PROGCOUNT = 1; ALU_RESULT = 8'h40; tick(); idle();
        n_cmp++; if (PC !== 8'h40) begin n_bad++; $display("FAIL call_pc got %h want 40", PC); end
        n_cmp++; if (STACK_DEPTH !== 8'h01) begin n_bad++; $display("FAIL call_depth got %h want 01", STACK_DEPTH); end
        INC_STACKPTR = 1; tick(); idle();
        n_cmp++; if (SP_OUT !== 8'hFF) begin n_bad++; $display("FAIL ret_sp got %h want ff", SP_OUT); end
        READ_STACKPTR = 1; WRITE_MEMADDR = 1; tick(); idle();
        n_cmp++; if (MAR !== 8'hFF) begin n_bad++; $display("FAIL ret_mar got %h want ff", MAR); end
        READ_MEM = 1; WRITE_PROGCOUNT = 1; MEM_RDATA = 8'h12; ALU_RESULT = 8'h99; tick(); idle();
        n_cmp++; if (PC !== 8'h12) begin n_bad++; $display("FAIL ret_pc got %h want 12", PC); end
        // MAR from the ALU bus
        WRITE_MEMADDR = 1; ALU_RESULT = 8'h5A; tick(); idle();
        n_cmp++; if (MAR !== 8'h5A) begin n_bad++; $display("FAIL mar_alu got %h want 5a", MAR); end
    endtask

    task automatic test_priority();
        idle(); WRITE_PROGCOUNT = 1; ALU_RESULT = 8'h05; tick(); idle();
        CLR_PROGCOUNT = 1; WRITE_PROGCOUNT = 1; INC_PROGCOUNT = 1; ALU_RESULT = 8'h33; tick(); idle();
        n_cmp++; if (PC !== 8'h00) begin n_bad++; $display("FAIL prio_clr got %h want 00", PC); end
        WRITE_PROGCOUNT = 1; INC_PROGCOUNT = 1; ALU_RESULT = 8'h20; tick(); idle();
        n_cmp++; if (PC !== 8'h20) begin n_bad++; $display("FAIL prio_wr got %h want 20", PC); end
        WRITE_PROGCOUNT = 1; ALU_RESULT = 8'hFF; tick(); idle();
        INC_PROGCOUNT = 1; tick(); idle();
        n_cmp++; if (PC !== 8'h00) begin n_bad++; $display("FAIL pc_wrap got %h want 00", PC); end
        INC_STACKPTR = 1; DEC_STACKPTR = 1; tick(); idle();
        n_cmp++; if (SP_OUT !== 8'hFF) begin n_bad++; $display("FAIL incdec_sp got %h want ff", SP_OUT); end
        n_cmp++; if ({STACK_OVF, STACK_UNF} !== 2'b00) begin n_bad++; $display("FAIL incdec_flags got %b want 00", {STACK_OVF, STACK_UNF}); end
    endtask

    task automatic test_stack_guard();
        idle(); PRESET_STACKPTR = 1; tick(); idle();
        READ_STACKPTR = 1; WRITE_MEMADDR = 1; DEC_STACKPTR = 1;
        repeat (64) tick();
        n_cmp++; if (SP_OUT !== 8'hBF) begin n_bad++; $display("FAIL push64_sp got %h want bf", SP_OUT); end
        n_cmp++; if (STACK_OVF !== 1'b0) begin n_bad++; $display("FAIL push64_ovf got %b want 0", STACK_OVF); end
        n_cmp++; if (MAR !== 8'hC0) begin n_bad++; $display("FAIL push64_mar got %h want c0", MAR); end
        tick(); idle();
        n_cmp++; if (SP_OUT !== EXP_SP_OVF) begin n_bad++; $display("FAIL push65_sp got %h want %h", SP_OUT, EXP_SP_OVF); end
        n_cmp++; if (STACK_OVF !== EXP_OVF) begin n_bad++; $display("FAIL push65_ovf got %b want %b", STACK_OVF, EXP_OVF); end
        n_cmp++; if (MAR !== 8'hBF) begin n_bad++; $display("FAIL push65_mar got %h want bf", MAR); end
        n_cmp++; if (STACK_DEPTH !== EXP_DEP_OVF) begin n_bad++; $display("FAIL push65_depth got %h want %h", STACK_DEPTH, EXP_DEP_OVF); end
        PRESET_STACKPTR = 1; tick(); idle();
        n_cmp++; if (SP_OUT !== 8'hFF) begin n_bad++; $display("FAIL preset_sp got %h want ff", SP_OUT); end
        n_cmp++; if (STACK_OVF !== 1'b0) begin n_bad++; $display("FAIL preset_ovf got %b want 0", STACK_OVF); end
        INC_STACKPTR = 1; tick(); idle();
        n_cmp++; if (SP_OUT !== EXP_SP_UNF) begin n_bad++; $display("FAIL unf_sp got %h want %h", SP_OUT, EXP_SP_UNF); end
        n_cmp++; if (STACK_UNF !== EXP_UNF) begin n_bad++; $display("FAIL unf_flag got %b want %b", STACK_UNF, EXP_UNF); end
        DEC_STACKPTR = 1; tick(); idle();
        n_cmp++; if (STACK_UNF !== EXP_UNF) begin n_bad++; $display("FAIL unf_sticky got %b want %b", STACK_UNF, EXP_UNF); end
    endtask

    task automatic test_start();
        idle(); WRITE_PROGCOUNT = 1; ALU_RESULT = 8'h9C; DEC_STACKPTR = 1; tick(); idle();
        CLR_PROGCOUNT = 1; PRESET_STACKPTR = 1; DEC_STACKPTR = 1; tick(); idle();
        n_cmp++; if (PC !== 8'h00) begin n_bad++; $display("FAIL start_pc got %h want 00", PC); end
        n_cmp++; if (SP_OUT !== 8'hFF) begin n_bad++; $display("FAIL start_sp got %h want ff", SP_OUT); end
        n_cmp++; if ({STACK_OVF, STACK_UNF} !== 2'b00) begin n_bad++; $display("FAIL start_flags got %b want 00", {STACK_OVF, STACK_UNF}); end
    endtask

    task automatic test_random();
        logic [7:0] exp_wd;
        for (int i = 0; i < 600; i++) begin
            RESET           = ($urandom_range(0, 99) == 0);
            INC_PROGCOUNT   = ($urandom_range(0, 2) == 0);
            CLR_PROGCOUNT   = ($urandom_range(0, 15) == 0);
            WRITE_PROGCOUNT = ($urandom_range(0, 3) == 0);
            READ_PROGCOUNT  = ($urandom_range(0, 1) == 0);
            READ_MEM        = ($urandom_range(0, 1) == 0);
            WRITE_MEMADDR   = ($urandom_range(0, 1) == 0);
            PRESET_STACKPTR = ($urandom_range(0, 31) == 0);
            INC_STACKPTR    = ($urandom_range(0, 2) == 0);
            DEC_STACKPTR    = ($urandom_range(0, 2) != 0);
            READ_STACKPTR   = ($urandom_range(0, 1) == 0);
            ALU_RESULT      = 8'($urandom);
            MEM_RDATA       = 8'($urandom);
            #1;
            exp_wd = READ_PROGCOUNT ? 8'(m_pc) : ALU_RESULT;
            n_cmp++; if (MEM_WDATA !== exp_wd) begin n_bad++; $display("FAIL rnd_wdata[%0d] got %h want %h", i, MEM_WDATA, exp_wd); end
            tick();
            n_cmp++; if (PC !== 8'(m_pc)) begin n_bad++; $display("FAIL rnd_pc[%0d] got %h want %h", i, PC, 8'(m_pc)); end
            n_cmp++; if (SP_OUT !== 8'(m_sp)) begin n_bad++; $display("FAIL rnd_sp[%0d] got %h want %h", i, SP_OUT, 8'(m_sp)); end
            n_cmp++; if (MAR !== 8'(m_mar)) begin n_bad++; $display("FAIL rnd_mar[%0d] got %h want %h", i, MAR, 8'(m_mar)); end
            n_cmp++; if (STACK_DEPTH !== 8'(255 - m_sp)) begin n_bad++; $display("FAIL rnd_depth[%0d] got %h want %h", i, STACK_DEPTH, 8'(255 - m_sp)); end
            n_cmp++; if ({STACK_OVF, STACK_UNF} !== {m_ovf, m_unf}) begin n_bad++; $display("FAIL rnd_flags[%0d] got %b want %b", i, {STACK_OVF, STACK_UNF}, {m_ovf, m_unf}); end
        end
        idle();
    endtask

    initial begin
        m_pc = 0; m_sp = 255; m_mar = 0; m_ovf = 0; m_unf = 0;
        idle();
        test_reset();
        test_call_ret();
        test_priority();
        test_stack_guard();
        test_start();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Downstream of the control unit: owns the program counter (PC), stack pointer (SP) and memory address register (MAR).
- Executes the PC, SP and MAR strobes issued each cycle by the control FSM.
- Supplies the instruction-memory address, data-memory address and data-memory write data.
- Holds the CALL/RET return-address path and stack-bounds fault detection.

Parameters:
- PC_WIDTH, 8, width of the program counter and instruction address.
- ADDR_WIDTH, 8, width of the data-memory address, SP and MAR.
- SP_INIT, 8'hFF, SP value on reset/preset; top of stack (empty).
- SP_LIMIT, 8'hC0, lowest legal stack slot. Must satisfy 1 <= SP_LIMIT <= SP_INIT.

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  reset, synchronous, active-high
- INC_PROGCOUNT  in  1  PC <= PC+1
- CLR_PROGCOUNT  in  1  PC <= 0
- WRITE_PROGCOUNT  in  1  load PC (source selected by READ_MEM)
- READ_PROGCOUNT  in  1  drive PC onto MEM_WDATA
- READ_MEM  in  1  qualifies PC load source = MEM_RDATA
- WRITE_MEMADDR  in  1  load MAR
- PRESET_STACKPTR  in  1  SP <= SP_INIT, clear faults
- INC_STACKPTR  in  1  SP <= SP+1
- DEC_STACKPTR  in  1  SP <= SP-1
- READ_STACKPTR  in  1  MAR source = SP (else ALU_RESULT)
- ALU_RESULT  in  8  ALU output bus
- MEM_RDATA  in  8  data-memory read data
- PC  out  PC_WIDTH  instruction-memory address (registered)
- MAR  out  ADDR_WIDTH  data-memory address (registered)
- MEM_WDATA  out  8  READ_PROGCOUNT ? zero-extended/truncated PC : ALU_RESULT (combinational)
- SP_OUT  out  ADDR_WIDTH  current SP (registered)
- STACK_DEPTH  out  ADDR_WIDTH  SP_INIT - SP (combinational)
- STACK_OVF  out  1  sticky overflow fault
- STACK_UNF  out  1  sticky underflow fault

Behaviour:
- Reset (RESET=1 at edge): PC=0, SP=SP_INIT, MAR=0, STACK_OVF=0, STACK_UNF=0. Reset overrides all strobes, including mid-CALL or mid-PUSH.
- All register updates take effect at the next rising edge (1-cycle latency). Outputs reflect the new value in the following cycle.
- PC priority: CLR_PROGCOUNT > WRITE_PROGCOUNT > INC_PROGCOUNT > hold.
  - WRITE source is MEM_RDATA when READ_MEM=1 (RET), otherwise ALU_RESULT (JMP/BRBx/CALL/IJMP/ICALL).
  - INC wraps modulo 2^PC_WIDTH (max -> 0). Values are truncated/zero-extended to PC_WIDTH.
- SP priority: PRESET_STACKPTR > (INC xor DEC) > hold. INC and DEC asserted together means hold, with no fault.
- Stack model: full-descending, SP points at the next free slot.
  - PUSH/CALL/ICALL: MAR <= old SP and SP <= SP-1 in the same cycle (READ_STACKPTR+WRITE_MEMADDR+DEC).
  - POP/RET: SP <= SP+1 first, then MAR <= SP the next cycle.
  - Legal SP range is [SP_LIMIT-1 (full), SP_INIT (empty)].
- MAR: loads on WRITE_MEMADDR from SP (READ_STACKPTR=1) or from ALU_RESULT[ADDR_WIDTH-1:0]. MAR always samples the pre-update SP.
- Fault conditions:
  - Overflow: DEC_STACKPTR (without INC/PRESET) while SP == SP_LIMIT-1.
  - Underflow: INC_STACKPTR (without DEC/PRESET) while SP == SP_INIT.
  - Handling of SP and flags at a fault depends on STACK_GUARD_EN (see Optional Feature).
- STACK_DEPTH: SP_INIT - SP modulo 2^ADDR_WIDTH. It reads 0 after reset/preset.
- The START sequence (CLR_PROGCOUNT + PRESET_STACKPTR together) gives PC=0, SP=SP_INIT and cleared faults in one edge.

Optional Feature:
- Macro: YASAC_STACK_GUARD_EN.
- Defined:
  - On an overflow or underflow event SP holds (saturates) and the matching flag sets.
  - Flags are sticky until PRESET_STACKPTR or RESET.
  - MAR still loads normally.
- Undefined:
  - SP wraps modulo 2^ADDR_WIDTH.
  - STACK_OVF and STACK_UNF are tied to 0.
  - No guard logic is synthesised.

Test Plan:
- Reset, then 3 cycles of INC_PROGCOUNT -> PC=3, SP=8'hFF, MAR=0, flags 0. Assert RESET mid-sequence -> PC=0 at next edge.
- CALL: PC=8'h12; cycle 1 READ_STACKPTR+WRITE_MEMADDR+DEC -> MAR=8'hFF, SP=8'hFE; cycle 2 READ_PROGCOUNT -> MEM_WDATA=8'h12; cycle 3 WRITE_PROGCOUNT with ALU_RESULT=8'h40 -> PC=8'h40, STACK_DEPTH=1.
- RET from the above: INC -> SP=8'hFF; READ_STACKPTR+WRITE_MEMADDR -> MAR=8'hFF; READ_MEM+WRITE_PROGCOUNT with MEM_RDATA=8'h12 -> PC=8'h12.
- Priority: CLR+WRITE+INC together at PC=8'h05 -> PC=0. WRITE+INC with ALU_RESULT=8'h20 -> PC=8'h20. INC at PC=8'hFF -> PC=0.
- Guard on, SP_LIMIT=8'hC0: 64 PUSHes -> SP=8'hBF, no fault; 65th DEC -> SP stays 8'hBF, STACK_OVF=1; PRESET -> SP=8'hFF, flag 0.
- Guard on: INC at SP=8'hFF -> SP=8'hFF, STACK_UNF=1. Guard off: same stimulus -> SP=8'h00, STACK_UNF=0.
